pass_sender: RTL
================

PASS_SENDER -- requirements
Module: pass_sender

Interface
REQ-001 Parameter DEPTH, default 16, meaning maximum number of stored password characters (power of 2, 2..64).
REQ-002 Parameter GAP, default 0, meaning idle cycles inserted between consecutive transmitted characters (0..15).
REQ-003 clock  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 wr_en  input  1  load strobe: append wr_data to buffer.
REQ-006 wr_data  input  8  ASCII character to append.
REQ-007 clear  input  1  empty the buffer and clear overflow.
REQ-008 start  input  1  begin transmitting stored characters.
REQ-009 en  output  1  character-valid strobe toward the password checker's en input.
REQ-010 data_out  output  8  character toward the checker's data_in; valid when en=1.
REQ-011 busy  output  1  transmission in progress.
REQ-012 done  output  1  one-cycle pulse: transmission finished.
REQ-013 len  output  clog2(DEPTH)+1  number of stored characters.
REQ-014 overflow  output  1  sticky: write attempted with buffer full.

Function
REQ-015 The FSM SHALL have states IDLE, SEND, GAP_WAIT, FIN; all outputs SHALL be registered.
REQ-016 In IDLE, wr_en with len<DEPTH SHALL store wr_data at index len and increment len next cycle.
REQ-017 In IDLE, wr_en with len==DEPTH SHALL leave buffer and len unchanged and set overflow.
REQ-018 wr_en and clear while busy=1 SHALL be ignored, overflow unaffected.
REQ-019 In IDLE, clear SHALL set len=0 and overflow=0; clear with wr_en same cycle: clear wins, no write.
REQ-020 In IDLE, start with len>0 SHALL enter SEND; first en=1 with data_out=buf[0] appears in the cycle after start is sampled; busy=1 from that same cycle.
REQ-021 In IDLE, start with len==0 SHALL go to FIN: done pulses one cycle after start, no en pulse.
REQ-022 start with wr_en/clear in the same IDLE cycle: write/clear applied first, start evaluated against updated len (next cycle).
REQ-023 SEND SHALL drive en=1 for exactly one cycle per character, characters in load order buf[0]..buf[len-1].
REQ-024 After each non-final character, GAP_WAIT SHALL hold en=0 for exactly GAP cycles (GAP=0: back-to-back en, no GAP_WAIT visit).
REQ-025 After the final character, FSM SHALL enter FIN: en=0, busy=0, done=1 for one cycle, then IDLE.
REQ-026 data_out SHALL be 8'h00 whenever en=0.
REQ-027 start while busy=1 or in FIN SHALL be ignored.
REQ-028 Buffer contents and len SHALL be retained after transmission; a new start re-sends the same string.
REQ-029 Total transmission of L>0 characters SHALL take L + (L-1)*GAP cycles of busy, done on the following cycle.
REQ-030 Read index SHALL not wrap: transmission stops at len-1 even when len==DEPTH.

Reset
REQ-031 reset=1 SHALL, at the next edge, force state IDLE, en=0, data_out=0, busy=0, done=0, len=0, overflow=0, read index=0.
REQ-032 reset SHALL override all other inputs, including mid-transmission; buffer RAM contents need not be cleared.
REQ-033 After reset deassertion, a start in the first cycle SHALL behave per REQ-021 (len==0).

Verification
REQ-034 Load "abc" (3 wr_en), GAP=0, start -> en high 3 consecutive cycles with 61,62,63, done on 4th cycle, len=3.
REQ-035 GAP=2, load "xy", start -> en pattern 1,0,0,1 with 78,_,_,79, then done=1, busy=0.
REQ-036 DEPTH=16: 17 writes -> len=16, overflow=1; clear -> len=0, overflow=0.
REQ-037 start with len=0 -> done one cycle later, en never asserted; start/wr_en during busy -> ignored, len unchanged.
REQ-038 reset asserted on 2nd character of 5 -> next cycle en=0, busy=0, len=0, no done pulse.
REQ-039 Re-start after completion -> identical character sequence re-sent.

Source files
------------

// File: rtl/pass_sender.sv
// Password sender: buffers up to DEPTH ASCII characters and replays them, one
// en strobe per character with GAP idle cycles between, toward a password checker.
module pass_sender #(
  parameter int DEPTH = 16,
  parameter int GAP   = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clear,
  input  logic                     start,
  output logic                     en,
  output logic [7:0]               data_out,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   len,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [3:0]    GAP_M1  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SEND, GAP_WAIT, FIN} state_t;

  state_t        state, state_d;
  logic [LW-1:0] rd_idx, rd_d, len_d;
  logic [3:0]    gap_cnt, gap_d;
  logic          start_pend, pend_d;
  logic          en_d, busy_d, done_d, ovf_d;
  logic [7:0]    data_d;
  logic          mem_we;
  logic [7:0]    mem [DEPTH];

  // Buffer RAM has no reset; only len decides which entries are meaningful.
  always_ff @(posedge clock) begin
    if (mem_we) mem[len[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rd_idx     <= '0;
      gap_cnt    <= '0;
      start_pend <= 1'b0;
      en         <= 1'b0;
      data_out   <= 8'h00;
      busy       <= 1'b0;
      done       <= 1'b0;
      len        <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_d;
      rd_idx     <= rd_d;
      gap_cnt    <= gap_d;
      start_pend <= pend_d;
      en         <= en_d;
      data_out   <= data_d;
      busy       <= busy_d;
      done       <= done_d;
      len        <= len_d;
      overflow   <= ovf_d;
    end
  end

  // rd_idx always points at the next character to emit, so the outputs
  // registered at each edge describe the state being entered.
  always_comb begin
    state_d = state;
    rd_d    = rd_idx;
    gap_d   = gap_cnt;
    pend_d  = start_pend;
    en_d    = 1'b0;
    data_d  = 8'h00;
    busy_d  = busy;
    done_d  = 1'b0;
    len_d   = len;
    ovf_d   = overflow;
    mem_we  = 1'b0;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (clear) begin
          len_d = '0;
          ovf_d = 1'b0;
        end else if (wr_en) begin
          if (len < DEPTH_L) begin
            mem_we = 1'b1;
            len_d  = len + LW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        // A start coinciding with a buffer edit is held one cycle so it sees the new len.
        if (start || start_pend) begin
          if (wr_en || clear) begin
            pend_d = 1'b1;
          end else begin
            pend_d = 1'b0;
            if (len != '0) begin
              state_d = SEND;
              en_d    = 1'b1;
              data_d  = mem[AW'(0)];
              busy_d  = 1'b1;
              rd_d    = LW'(1);
            end else begin
              state_d = FIN;
              done_d  = 1'b1;
            end
          end
        end
      end

      SEND: begin
        busy_d = 1'b1;
        if (rd_idx == len) begin
          state_d = FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rd_d    = '0;
        end else if (GAP == 0) begin
          en_d   = 1'b1;
          data_d = mem[rd_idx[AW-1:0]];
          rd_d   = rd_idx + LW'(1);
        end else begin
          state_d = GAP_WAIT;
          gap_d   = GAP_M1;
        end
      end

      GAP_WAIT: begin
        busy_d = 1'b1;
        if (gap_cnt == 4'd0) begin
          state_d = SEND;
          en_d    = 1'b1;
          data_d  = mem[rd_idx[AW-1:0]];
          rd_d    = rd_idx + LW'(1);
        end else begin
          gap_d = gap_cnt - 4'd1;
        end
      end

      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
